// File: rtl/nor_lane_serializer.sv
// rtl/nor_lane_serializer.sv - buffers NOR lane vectors and emits them as LSB-first frames with even parity
module nor_lane_serializer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         ser_valid,
    output logic                         ser_out,
    output logic                         ser_first,
    output logic                         ser_last,
    input  logic                         ser_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             xfer;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready   = (count != CW'(DEPTH)) & ~reset;
    assign push       = in_valid & in_ready;
    assign xfer       = ser_valid & ser_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = (count != '0);
            PARITY:  pop = xfer && (count != '0);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            par   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= head;
                        par   <= ^head;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shreg <= shreg >> 1;
                        idx   <= idx + 1'b1;
                        if (idx == IW'(WIDTH - 1)) state <= PARITY;
                    end
                end
                PARITY: begin
                    // Reload straight from the FIFO so consecutive frames have no idle bubble.
                    if (xfer) begin
                        if (pop) begin
                            shreg <= head;
                            par   <= ^head;
                            idx   <= '0;
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ser_valid = (state == DATA) || (state == PARITY);
    assign ser_out   = (state == DATA) ? shreg[0] : ((state == PARITY) ? par : 1'b0);
    assign ser_first = (state == DATA) && (idx == '0);
    assign ser_last  = (state == PARITY);

endmodule

// File: tb/tb_nor_lane_serializer.sv
// tb/tb_nor_lane_serializer.sv - directed-vector bench for nor_lane_serializer
module tb_nor_lane_serializer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       ser_valid;
    logic       ser_out;
    logic       ser_first;
    logic       ser_last;
    logic       ser_ready;
    logic [1:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;

    nor_lane_serializer #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ser_valid  (ser_valid),
        .ser_out    (ser_out),
        .ser_first  (ser_first),
        .ser_last   (ser_last),
        .ser_ready  (ser_ready),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; ser_ready = 1'b0;
        tick; tick;
        n_vec++;
        if ({ser_valid, ser_out, ser_first, ser_last, in_ready, fifo_count} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_state: v/o/f/l/rdy/cnt=%b%b%b%b%b/%0d required all 0",
                     ser_valid, ser_out, ser_first, ser_last, in_ready, fifo_count);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_single_word;
        logic [0:4] seq;
        seq = 5'b1000_1;
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b0001;
        tick;
        in_valid = 1'b0;
        n_vec++;
        if (ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency_early: ser_valid=%b required 0", ser_valid);
        end
        tick;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ser_valid !== 1'b1 || ser_out !== seq[i] || ser_first !== (i == 0) || ser_last !== (i == 4)) begin
                n_err++;
                $display("FAIL single_bit%0d: v/o/f/l=%b%b%b%b required 1%b%b%b",
                         i, ser_valid, ser_out, ser_first, ser_last, seq[i], i == 0, i == 4);
            end
            tick;
        end
        n_vec++;
        if (ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_end: ser_valid=%b required 0", ser_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [0:9] seq;
        seq = 10'b11110_01100;
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b1111;
        tick;
        in_data = 4'b0110;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (ser_valid !== 1'b1 || ser_out !== seq[i] || ser_first !== (i % 5 == 0) || ser_last !== (i % 5 == 4)) begin
                n_err++;
                $display("FAIL b2b_bit%0d: v/o/f/l=%b%b%b%b required 1%b%b%b",
                         i, ser_valid, ser_out, ser_first, ser_last, seq[i], i % 5 == 0, i % 5 == 4);
            end
            tick;
        end
        n_vec++;
        if (ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: ser_valid=%b required 0", ser_valid);
        end
    endtask

    task automatic test_backpressure;
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b1010;
        tick;
        in_valid = 1'b0;
        tick;
        n_vec++;
        if (ser_out !== 1'b0 || ser_first !== 1'b1) begin
            n_err++;
            $display("FAIL bp_bit0: out/first=%b%b required 01", ser_out, ser_first);
        end
        tick;
        ser_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ser_valid !== 1'b1 || ser_out !== 1'b1 || ser_first !== 1'b0 || ser_last !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: v/o/f/l=%b%b%b%b required 1100",
                         i, ser_valid, ser_out, ser_first, ser_last);
            end
            if (i == 3) ser_ready = 1'b1;
            else tick;
        end
        tick;
        n_vec++;
        if (ser_out !== 1'b0 || ser_last !== 1'b0) begin
            n_err++;
            $display("FAIL bp_bit2: out/last=%b%b required 00", ser_out, ser_last);
        end
        tick;
        n_vec++;
        if (ser_out !== 1'b1 || ser_last !== 1'b0) begin
            n_err++;
            $display("FAIL bp_bit3: out/last=%b%b required 10", ser_out, ser_last);
        end
        tick;
        n_vec++;
        if (ser_valid !== 1'b1 || ser_out !== 1'b0 || ser_last !== 1'b1) begin
            n_err++;
            $display("FAIL bp_parity: v/out/last=%b%b%b required 101", ser_valid, ser_out, ser_last);
        end
        tick;
        n_vec++;
        if (ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: ser_valid=%b required 0", ser_valid);
        end
    endtask

    task automatic test_full_fifo;
        logic [0:14] seq;
        seq = 15'b11000_10100_10111;
        ser_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b0011;
        tick;
        in_data = 4'b0101;
        tick;
        in_data = 4'b1101;
        tick;
        n_vec++;
        if (fifo_count !== 2'd2 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_count: cnt=%0d in_ready=%b required 2/0", fifo_count, in_ready);
        end
        in_data = 4'b1110;
        tick;
        in_valid = 1'b0;
        n_vec++;
        if (fifo_count !== 2'd2) begin
            n_err++;
            $display("FAIL full_reject: cnt=%0d required 2", fifo_count);
        end
        ser_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if (ser_valid !== 1'b1 || ser_out !== seq[i] || ser_first !== (i % 5 == 0) || ser_last !== (i % 5 == 4)) begin
                n_err++;
                $display("FAIL full_drain_bit%0d: v/o/f/l=%b%b%b%b required 1%b%b%b",
                         i, ser_valid, ser_out, ser_first, ser_last, seq[i], i % 5 == 0, i % 5 == 4);
            end
            tick;
        end
        n_vec++;
        if (ser_valid !== 1'b0 || fifo_count !== 2'd0) begin
            n_err++;
            $display("FAIL full_end: v=%b cnt=%0d required 0/0", ser_valid, fifo_count);
        end
    endtask

    task automatic test_reset_mid_frame;
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b0111;
        tick;
        in_data = 4'b1000;
        tick;
        in_valid = 1'b0;
        tick; tick;
        n_vec++;
        if (ser_valid !== 1'b1 || ser_out !== 1'b1 || fifo_count !== 2'd1) begin
            n_err++;
            $display("FAIL rst_mid_pre: v/o=%b%b cnt=%0d required 11/1", ser_valid, ser_out, fifo_count);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({ser_valid, ser_out, ser_first, ser_last, in_ready, fifo_count} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: v/o/f/l/rdy/cnt=%b%b%b%b%b/%0d required all 0",
                     ser_valid, ser_out, ser_first, ser_last, in_ready, fifo_count);
        end
        tick;
        reset = 1'b0;
        #1;
        n_vec++;
        if (fifo_count !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_release: cnt=%0d in_ready=%b required 0/1", fifo_count, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            n_vec++;
            if (ser_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_quiet%0d: ser_valid=%b required 0", i, ser_valid);
            end
        end
    endtask

    task automatic test_push_pop_same_cycle;
        logic [0:4]  seq1;
        logic [0:9]  seq23;
        seq1  = 5'b0100_1;
        seq23 = 10'b00101_11011;
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b0010;
        tick;
        in_data = 4'b0100;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ser_valid !== 1'b1 || ser_out !== seq1[i] || ser_last !== (i == 4)) begin
                n_err++;
                $display("FAIL pp_first_bit%0d: v/o/l=%b%b%b required 1%b%b",
                         i, ser_valid, ser_out, ser_last, seq1[i], i == 4);
            end
            if (i == 4) begin
                in_valid = 1'b1;
                in_data  = 4'b1011;
            end
            tick;
        end
        in_valid = 1'b0;
        n_vec++;
        if (fifo_count !== 2'd1) begin
            n_err++;
            $display("FAIL pp_count: cnt=%0d required 1", fifo_count);
        end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (ser_valid !== 1'b1 || ser_out !== seq23[i] || ser_first !== (i % 5 == 0) || ser_last !== (i % 5 == 4)) begin
                n_err++;
                $display("FAIL pp_next_bit%0d: v/o/f/l=%b%b%b%b required 1%b%b%b",
                         i, ser_valid, ser_out, ser_first, ser_last, seq23[i], i % 5 == 0, i % 5 == 4);
            end
            tick;
        end
        n_vec++;
        if (ser_valid !== 1'b0 || fifo_count !== 2'd0) begin
            n_err++;
            $display("FAIL pp_end: v=%b cnt=%0d required 0/0", ser_valid, fifo_count);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        tick;
        test_back_to_back;
        tick;
        test_backpressure;
        tick;
        test_full_fifo;
        tick;
        test_reset_mid_frame;
        tick;
        test_push_pop_same_cycle;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nor_lane_serializer.md
# nor_lane_serializer

Downstream stage of the 4-lane NOR array. Accepts each packed NOR result vector (lane 0 in bit 0) through a valid/ready handshake and buffers it in a small FIFO. Each vector is sent out as a bit-serial frame: WIDTH data bits LSB-first, followed by one even-parity bit. The frame is delimited by first/last flags for the display/checker logic further down.

## Interface
- WIDTH, 4, number of NOR lanes, i.e. data bits per frame (≥2)
- DEPTH, 2, FIFO entries (power of 2, ≥2)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  in_data holds a NOR result vector
- in_data  input  WIDTH  packed NOR outputs, bit i = out_i
- in_ready  output  1  FIFO can accept; push = in_valid & in_ready at clk edge
- ser_valid  output  1  ser_out holds a frame bit
- ser_out  output  1  current serial bit
- ser_first  output  1  ser_out is data bit 0 of a frame
- ser_last  output  1  ser_out is the parity bit
- ser_ready  input  1  consumer takes the bit; transfer = ser_valid & ser_ready at clk edge
- fifo_count  output  $clog2(DEPTH+1)  entries currently buffered (excludes the word being shifted)

## Operation
- FIFO: circular, read/write pointers wrap modulo DEPTH.
  - in_ready = (fifo_count != DEPTH) & ~reset. It depends on registered count only.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, no push is accepted even if a pop occurs that cycle.
- FSM states IDLE, DATA, PARITY.
  - IDLE: ser_valid=0. If fifo_count>0: pop the head into the shift register, latch parity = ^word, clear bit index, go to DATA.
  - DATA: ser_valid=1, ser_out=shreg[0], ser_first=(index==0).
    - On transfer: shift right and increment the index.
    - On the transfer of index WIDTH-1, go to PARITY.
  - PARITY: ser_valid=1, ser_out=parity, ser_last=1.
    - On transfer with fifo_count>0: pop the next word and go to DATA, with no idle bubble.
    - On transfer with fifo_count==0: go to IDLE.
- Frame parity is even: the data bits plus the parity bit contain an even number of ones.
- With ser_ready low, ser_out, ser_first, ser_last and ser_valid are held stable. No bit is skipped or repeated.
- A push into an empty FIFO in the same cycle the FSM pops is not visible until the next cycle. The FSM pops only when registered count>0.

## Timing
- Reset values: ser_valid=0, ser_out=0, ser_first=0, ser_last=0, fifo_count=0, in_ready=0 while reset is high. in_ready=1 from the first cycle after release.
- Latency: a push at edge k into an empty, idle block gives ser_valid=1 with ser_first=1 after edge k+1.
- Frame length is WIDTH+1 transfers. With ser_ready held high, back-to-back frames are contiguous: WIDTH+1 cycles each, no gap.
- Reset asserted mid-frame aborts the frame at once and discards FIFO contents; no partial frame resumes.
- The shift register and the FIFO occupy separate storage. Throughput is therefore DEPTH+1 words in flight.

## Test plan
- Single word: reset, then push in_data=4'b0001 (NOR of 00,01,10,11) with ser_ready=1 → ser_out 1,0,0,0 then parity 1. ser_first on bit 1, ser_last on bit 5, then ser_valid=0.
- Back-to-back: push 4'b1111, then 4'b0110 on consecutive cycles with ser_ready=1 → 10 contiguous valid cycles: 1,1,1,1,0 then 0,1,1,0,0, no gap.
- Backpressure: push 4'b1010. Hold ser_ready=0 for 3 cycles during data bit 1, then release → ser_out stays 1 (bit 1) for all 4 cycles. Remaining bits 0,1 and parity 0 follow.
- Full FIFO: ser_ready=0, push 4 words on consecutive cycles → the first loads the shift register, the next two fill the FIFO (fifo_count=2), and in_ready=0 so the 4th is not accepted. Releasing ser_ready drains the three accepted words in order.
- Reset mid-frame: assert reset during data bit 2 of a frame with 1 word queued → all outputs 0 immediately. After release: fifo_count=0, in_ready=1, no frame output.
- Simultaneous push/pop: with 1 word queued, push a new word on the same cycle PARITY completes → fifo_count stays 1. The next frame is the older word.
